// File: rtl/svi_serializer.sv
// Parallel-to-serial shifter: accepts a WIDTH-bit word and emits it LSB first,
// one bit per clock, with back-to-back reload on the final bit.
module svi_serializer #(
  parameter int WIDTH = 8
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_valid,
  input  logic [WIDTH-1:0]         i_data,
  output logic                     o_ready,
  output logic                     o_a,
  output logic                     o_valid,
  output logic                     o_last,
  output logic [$clog2(WIDTH)-1:0] o_count
);

  localparam int             CW   = $clog2(WIDTH);
  localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_data;
  logic [WIDTH-1:0] w_data_nxt;
  logic [CW-1:0]    r_count;
  logic [CW-1:0]    w_count_nxt;
  logic             w_at_last;
  logic             w_accept;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state <= IDLE;
      r_data  <= '0;
      r_count <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_data  <= w_data_nxt;
      r_count <= w_count_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_data_nxt  = r_data;
    w_count_nxt = r_count;

    w_at_last = (r_state == SHIFT) && (r_count == LAST);
    // The final bit cycle doubles as the load slot so words can stream gap-free.
    o_ready   = i_rst_n && ((r_state == IDLE) || w_at_last);
    w_accept  = i_valid && o_ready;

    case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_state_nxt = SHIFT;
          w_data_nxt  = i_data;
          w_count_nxt = '0;
        end
      end
      SHIFT: begin
        if (w_accept) begin
          w_data_nxt  = i_data;
          w_count_nxt = '0;
        end else if (w_at_last) begin
          w_state_nxt = IDLE;
          w_count_nxt = '0;
        end else begin
          w_count_nxt = r_count + CW'(1);
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_count_nxt = '0;
      end
    endcase

    o_valid = (r_state == SHIFT);
    o_a     = (r_state == SHIFT) ? r_data[r_count] : 1'b0;
    o_last  = w_at_last;
    o_count = r_count;
  end

endmodule

// File: tb/tb_svi_serializer.sv
// Bench for svi_serializer: directed scenarios plus a randomized loopback
// through a bit-per-clock deserializer.
module tb_svi_serializer;

  localparam int W = 8;

  logic         clk;
  logic         rst_n;
  logic         valid;
  logic [W-1:0] data;
  logic         ready;
  logic         a;
  logic         ovalid;
  logic         last;
  logic [2:0]   count;

  int checks = 0;
  int errors = 0;

  svi_serializer #(.WIDTH(W)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_valid (valid),
    .i_data  (data),
    .o_ready (ready),
    .o_a     (a),
    .o_valid (ovalid),
    .o_last  (last),
    .o_count (count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Loopback deserializer: rebuilds words from the serial stream.
  logic         des_en = 1'b0;
  logic [W-1:0] des_buf = '0;
  logic [W-1:0] recovered[$];
  always @(negedge clk) begin
    if (des_en && ovalid) begin
      des_buf[count] = a;
      if (last) recovered.push_back(des_buf);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; valid = 1'b1; data = 8'hFF;
    step();
    step();
    checks++;
    if (ovalid !== 1'b0 || a !== 1'b0 || last !== 1'b0 || count !== 3'd0) begin
      errors++;
      $display("FAIL reset_outputs: valid=%b a=%b last=%b count=%0d, want 0 0 0 0", ovalid, a, last, count);
    end
    checks++;
    if (ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_ready: ready=%b want 0", ready);
    end
    valid = 1'b0;
    rst_n = 1'b1;
    #1;
    checks++;
    if (ready !== 1'b1) begin
      errors++;
      $display("FAIL idle_ready: ready=%b want 1", ready);
    end
  endtask

  task automatic test_single_a5();
    logic [W-1:0] w;
    w = 8'hA5;
    valid = 1'b1; data = w;
    step();
    valid = 1'b0; data = 8'h00;
    for (int k = 0; k < W; k++) begin
      checks++;
      if (ovalid !== 1'b1 || a !== w[k] || last !== (k == W-1) || count !== 3'(k)) begin
        errors++;
        $display("FAIL a5_bit%0d: valid=%b a=%b last=%b count=%0d, want 1 %b %b %0d",
                 k, ovalid, a, last, count, w[k], (k == W-1), k);
      end
      step();
    end
    checks++;
    if (ovalid !== 1'b0 || a !== 1'b0 || last !== 1'b0 || count !== 3'd0) begin
      errors++;
      $display("FAIL a5_idle_after: valid=%b a=%b last=%b count=%0d, want 0 0 0 0", ovalid, a, last, count);
    end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] w;
    valid = 1'b1; data = 8'hFF;
    step();
    data = 8'h00;
    for (int c = 0; c < 2*W; c++) begin
      if (c == W) valid = 1'b0;
      w = (c < W) ? 8'hFF : 8'h00;
      checks++;
      if (ovalid !== 1'b1 || a !== w[c % W] || count !== 3'(c % W) || last !== ((c % W) == W-1)) begin
        errors++;
        $display("FAIL b2b_cycle%0d: valid=%b a=%b count=%0d last=%b, want 1 %b %0d %b",
                 c, ovalid, a, count, last, w[c % W], c % W, ((c % W) == W-1));
      end
      step();
    end
    checks++;
    if (ovalid !== 1'b0) begin
      errors++;
      $display("FAIL b2b_idle_after: valid=%b want 0", ovalid);
    end
  endtask

  task automatic test_ignore_busy();
    logic [W-1:0] w;
    w = 8'(($urandom & 32'hFF) | 32'h01);
    valid = 1'b1; data = w;
    step();
    valid = 1'b0;
    for (int k = 0; k < W; k++) begin
      if (k == 3) begin
        valid = 1'b1; data = 8'h3C;
        #1;
        checks++;
        if (ready !== 1'b0) begin
          errors++;
          $display("FAIL busy_ready: ready=%b want 0", ready);
        end
      end
      if (k == 4) valid = 1'b0;
      checks++;
      if (ovalid !== 1'b1 || a !== w[k] || count !== 3'(k)) begin
        errors++;
        $display("FAIL busy_bit%0d: valid=%b a=%b count=%0d, want 1 %b %0d", k, ovalid, a, count, w[k], k);
      end
      step();
    end
    checks++;
    if (ovalid !== 1'b0) begin
      errors++;
      $display("FAIL busy_idle_after: valid=%b want 0", ovalid);
    end
  endtask

  task automatic test_reset_midword();
    logic [W-1:0] w;
    w = 8'hF0;
    valid = 1'b1; data = w;
    step();
    valid = 1'b0;
    for (int k = 0; k < 4; k++) step();
    checks++;
    if (count !== 3'd4 || a !== w[4] || last !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_pre: count=%0d a=%b last=%b, want 4 %b 0", count, a, last, w[4]);
    end
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    checks++;
    if (ovalid !== 1'b0 || count !== 3'd0 || last !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_post: valid=%b count=%0d last=%b, want 0 0 0", ovalid, count, last);
    end
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (last !== 1'b0 || ovalid !== 1'b0) begin
        errors++;
        $display("FAIL rstmid_no_last%0d: valid=%b last=%b, want 0 0", k, ovalid, last);
      end
      step();
    end
    w = 8'h81;
    valid = 1'b1; data = w;
    step();
    valid = 1'b0;
    for (int k = 0; k < W; k++) begin
      checks++;
      if (ovalid !== 1'b1 || a !== w[k] || last !== (k == W-1)) begin
        errors++;
        $display("FAIL rstmid_81_bit%0d: valid=%b a=%b last=%b, want 1 %b %b", k, ovalid, a, last, w[k], (k == W-1));
      end
      step();
    end
  endtask

  task automatic test_data_change();
    logic [W-1:0] w;
    w = 8'h55;
    valid = 1'b1; data = w;
    step();
    valid = 1'b0;
    for (int k = 0; k < W; k++) begin
      data = (k == 0) ? 8'hAA : 8'($urandom);
      checks++;
      if (a !== w[k]) begin
        errors++;
        $display("FAIL datachg_bit%0d: a=%b want %b", k, a, w[k]);
      end
      step();
    end
  endtask

  task automatic test_random_loopback();
    logic [W-1:0] sent[$];
    logic [W-1:0] w;
    int rem;
    int gap;
    bit exp_ready;
    bit acc;
    int tries;
    int ready_errs;
    recovered.delete();
    des_en = 1'b1;
    rem = 0;
    ready_errs = 0;
    for (int n = 0; n < 256; n++) begin
      gap = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(1, 3);
      valid = 1'b0;
      for (int g = 0; g < gap; g++) begin
        data = 8'($urandom);
        step();
        rem = (rem > 0) ? rem - 1 : 0;
      end
      w = 8'($urandom);
      valid = 1'b1; data = w;
      acc = 1'b0;
      tries = 0;
      while (!acc && tries < 20) begin
        #1;
        exp_ready = (rem <= 1);
        checks++;
        if (ready !== exp_ready) begin
          errors++;
          ready_errs++;
          if (ready_errs <= 5)
            $display("FAIL loop_ready word%0d: ready=%b want %b", n, ready, exp_ready);
        end
        acc = exp_ready;
        step();
        rem = acc ? W : ((rem > 0) ? rem - 1 : 0);
        tries++;
      end
      checks++;
      if (!acc) begin
        errors++;
        $display("FAIL loop_accept_timeout word%0d: not accepted within 20 cycles", n);
      end
      sent.push_back(w);
      valid = 1'b0;
      data = 8'($urandom);
    end
    valid = 1'b0;
    for (int i = 0; i < 2*W; i++) step();
    des_en = 1'b0;
    checks++;
    if (recovered.size() != sent.size()) begin
      errors++;
      $display("FAIL loop_word_count: got %0d words, want %0d", recovered.size(), sent.size());
    end
    for (int i = 0; i < sent.size() && i < recovered.size(); i++) begin
      checks++;
      if (recovered[i] !== sent[i]) begin
        errors++;
        $display("FAIL loop_word%0d: got %h want %h", i, recovered[i], sent[i]);
      end
    end
  endtask

  initial begin
    rst_n = 1'b0; valid = 1'b0; data = '0;
    test_reset();
    test_single_a5();
    test_back_to_back();
    test_ignore_busy();
    test_reset_midword();
    test_data_change();
    test_random_loopback();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule

// File: doc/svi_serializer.md
SVI_SERIALIZER -- requirements
Module: svi_serializer

Interface
REQ-001 Parameter WIDTH, default 8: serial word width in bits; SHALL be >= 2.
REQ-002 i_clk  input  1: single clock; all state SHALL update on its rising edge only.
REQ-003 i_rst_n  input  1: synchronous, active-low reset, sampled on rising i_clk.
REQ-004 i_valid  input  1: parallel word offered.
REQ-005 i_data  input  WIDTH: parallel word, packed, bit 0 transmitted first.
REQ-006 o_ready  output  1: block accepts i_data this cycle.
REQ-007 o_a  output  1: serial data bit.
REQ-008 o_valid  output  1: o_a carries a word bit this cycle.
REQ-009 o_last  output  1: o_a carries bit WIDTH-1 of the current word.
REQ-010 o_count  output  $clog2(WIDTH): index of the bit currently on o_a.

Function
REQ-011 The block SHALL implement two states, IDLE and SHIFT, held in a registered state variable.
REQ-012 A word SHALL be accepted on a rising edge where i_valid=1, o_ready=1 and i_rst_n=1.
REQ-013 o_ready SHALL be combinational: 1 in IDLE; 1 in SHIFT only when o_count=WIDTH-1; 0 otherwise and 0 while i_rst_n=0.
REQ-014 On acceptance, i_data SHALL be captured into an internal WIDTH-bit packed register, o_count SHALL be set to 0 and the state SHALL become SHIFT.
REQ-015 Latency: bit k of an accepted word SHALL appear on o_a with o_valid=1 exactly k+1 cycles after the accepting edge, for k=0..WIDTH-1.
REQ-016 In SHIFT, o_a SHALL equal captured bit [o_count], and o_count SHALL increment by 1 per cycle.
REQ-017 o_last SHALL be 1 exactly when state is SHIFT and o_count=WIDTH-1.
REQ-018 At o_count=WIDTH-1 with a simultaneous acceptance, the new word SHALL be loaded, o_count SHALL wrap to 0 and the state SHALL remain SHIFT, with no idle cycle between words.
REQ-019 At o_count=WIDTH-1 with no acceptance, the state SHALL return to IDLE and o_valid SHALL be 0 on the next cycle.
REQ-020 o_count SHALL never exceed WIDTH-1; it returns to 0 only by reload, return to IDLE or reset.
REQ-021 In IDLE, o_valid=0, o_a=0, o_last=0 and o_count=0.
REQ-022 i_data changes after acceptance SHALL NOT affect the word in flight; i_valid while o_ready=0 SHALL be ignored without side effects.

Reset
REQ-023 With i_rst_n=0 at a rising edge, the state SHALL become IDLE and o_valid=0, o_a=0, o_last=0, o_count=0; the captured register SHALL be cleared to 0.
REQ-024 Reset SHALL take priority over acceptance and shifting; a word in flight SHALL be dropped without asserting o_last.
REQ-025 The first acceptance SHALL be possible on the first rising edge where i_rst_n=1.

Verification
REQ-026 Reset, then offer 8'hA5 for one cycle -> o_a = 1,0,1,0,0,1,0,1 on the next 8 cycles, o_valid=1 throughout, o_last only on the 8th, o_valid=0 on the 9th.
REQ-027 Hold i_valid=1 with 8'hFF then 8'h00 -> 16 consecutive o_valid cycles with no gap, o_last on cycles 8 and 16, o_count 0..7 twice.
REQ-028 Offer 8'h3C while shifting at o_count=3 -> o_ready=0, no acceptance, current word bits unchanged.
REQ-029 Drive i_rst_n=0 at o_count=4 of 8'hF0 -> next cycle o_valid=0, o_count=0, o_last never seen; a later 8'h81 serializes fully.
REQ-030 Change i_data from 8'h55 to 8'hAA one cycle after acceptance -> o_a still 1,0,1,0,1,0,1,0.
REQ-031 Loop o_a back into the matching 8-bit bit-per-clock deserializer interface -> recovered word equals the transmitted word for 256 random words.
